// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
//
// Purpose:
//   MIPS-style HI/LO multiply/divide unit. MULT/MULTU run a 32-step shift-add
//   multiplier; DIV/DIVU run a 32-step restoring divider. MTHI/MTLO write the
//   HI/LO registers directly in a single cycle when the unit is idle.
//
// Timing (edge 0 = the edge that accepts start):
//   edge 0       operands latched, FSM enters RUN, busy rises
//   edges 1..32  one iteration step per edge
//   edge 33      HI/LO written, done pulses, busy falls, FSM back in IDLE
//
// Configuration:
//   MULDIV_DIV_EN  when defined, the divider datapath is built and op 010/011
//                  run DIV/DIVU; when undefined those opcodes are no-ops.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   operation request
//   op     in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A      in   32  rs operand: multiplicand / dividend / MTHI-MTLO data
//   B      in   32  rt operand: multiplier / divisor
//   busy   out  1   iterative operation in flight
//   done   out  1   one-cycle pulse when HI/LO take a mul/div result
//   HI     out  32  product[63:32] or remainder
//   LO     out  32  product[31:0] or quotient

module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    // Set after the 32nd step; the following edge is the write-back edge.
    logic        fin_q, fin_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
`ifdef MULDIV_DIV_EN
    logic        div_q, div_d;
`endif
    // Working accumulator: partial product / partial remainder in acc_hi,
    // product low bits / quotient bits in acc_lo.
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    logic        accept;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_res;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [63:0] prod_fix;

    always_comb begin
        accept = start && ((op == OP_MULT) || (op == OP_MULTU)
`ifdef MULDIV_DIV_EN
                           || (op == OP_DIV) || (op == OP_DIVU)
`endif
                          );
    end

    assign mag_a   = mag(a_q, sgn_q);
    assign mag_b   = mag(b_q, sgn_q);
    assign neg_res = sgn_q & (a_q[31] ^ b_q[31]);

    // Shift-add step: the multiplier bit for step k is bit k of |B|; the
    // sum's low bit shifts down into the product low word.
    assign mul_sum  = {1'b0, acc_hi_q} + (mag_b[count_q] ? {1'b0, mag_a} : 33'd0);
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_res ? (~prod + 64'd1) : prod;

`ifdef MULDIV_DIV_EN
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. The difference is always below
    // the divisor, so 32 bits suffice for it.
    assign div_shift = {acc_hi_q, acc_lo_q[31]};
    assign div_ge    = (div_shift >= {1'b0, mag_b});
    assign div_sub   = div_shift[31:0] - mag_b;
    // Truncating division: quotient negative when signs differ, remainder
    // follows the dividend.
    assign quo_fix   = neg_res ? (~acc_lo_q + 32'd1) : acc_lo_q;
    assign rem_fix   = (sgn_q && a_q[31]) ? (~acc_hi_q + 32'd1) : acc_hi_q;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fin_d    = fin_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
`ifdef MULDIV_DIV_EN
        div_d    = div_q;
`endif
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    a_d      = A;
                    b_d      = B;
                    sgn_d    = ~op[0];
                    count_d  = 5'd0;
                    fin_d    = 1'b0;
                    acc_hi_d = 32'd0;
                    acc_lo_d = 32'd0;
`ifdef MULDIV_DIV_EN
                    div_d    = op[1];
                    if (op[1]) begin
                        acc_lo_d = mag(A, ~op[0]);
                    end
`endif
                end else if (start && (op == OP_MTHI)) begin
                    hi_d = A;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                if (!fin_q) begin
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        fin_d = 1'b1;
                    end
`ifdef MULDIV_DIV_EN
                    if (div_q) begin
                        acc_hi_d = div_ge ? div_sub : div_shift[31:0];
                        acc_lo_d = {acc_lo_q[30:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[32:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                    end
`else
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
`endif
                end else begin
                    state_d = S_IDLE;
                    fin_d   = 1'b0;
                    count_d = 5'd0;
                    done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                    if (div_q) begin
                        // Divide by zero reports all-ones quotient and the
                        // raw dividend, whatever the signedness.
                        if (b_q == 32'd0) begin
                            lo_d = 32'hFFFF_FFFF;
                            hi_d = a_q;
                        end else begin
                            lo_d = quo_fix;
                            hi_d = rem_fix;
                        end
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
`else
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            fin_q    <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sgn_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q    <= 1'b0;
`endif
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            fin_q    <= fin_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
`ifdef MULDIV_DIV_EN
            div_q    <= div_d;
`endif
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO as the reference model sees them.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operand values.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_i, input logic [31:0] lo_i,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output bit acc);
        longint          sa, sb, p;
        longint unsigned pu;
        hi_o = hi_i;
        lo_o = lo_i;
        acc  = 1'b0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (o)
            3'd0: begin
                p = sa * sb;
                hi_o = p[63:32];
                lo_o = p[31:0];
                acc = 1'b1;
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                hi_o = pu[63:32];
                lo_o = pu[31:0];
                acc = 1'b1;
            end
            3'd2, 3'd3: begin
                if (DIV_EN) begin
                    acc = 1'b1;
                    if (b == 32'd0) begin
                        lo_o = 32'hFFFF_FFFF;
                        hi_o = a;
                    end else if (o == 3'd2) begin
                        lo_o = 32'(sa / sb);
                        hi_o = 32'(sa % sb);
                    end else begin
                        lo_o = a / b;
                        hi_o = a % b;
                    end
                end
            end
            3'd4: hi_o = a;
            3'd5: lo_o = a;
            default: ;
        endcase
    endtask

    // Issue one op and follow it to completion. Optionally inject a second
    // start request at iteration inj_k (1..32) while the unit is busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inj_k, input logic [2:0] inj_op,
                          input logic [31:0] inj_a, input logic [31:0] inj_b);
        logic [31:0] ehi, elo;
        bit acc;
        int busy_bad = 0;
        int done_bad = 0;
        int hold_bad = 0;
        model(o, a, b, m_hi, m_lo, ehi, elo, acc);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        check({tag, "_busy_e0"}, busy, acc);
        check({tag, "_done_e0"}, done, 1'b0);
        if (!acc) begin
            check({tag, "_hilo_e0"}, {HI, LO}, {ehi, elo});
            m_hi = ehi;
            m_lo = elo;
            return;
        end
        check({tag, "_hold_e0"}, {HI, LO}, {m_hi, m_lo});
        for (int k = 1; k <= 32; k++) begin
            if (k == inj_k) begin
                start = 1'b1; op = inj_op; A = inj_a; B = inj_b;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if ({HI, LO} !== {m_hi, m_lo}) hold_bad++;
        end
        start = 1'b0;
        check({tag, "_busy_run"}, busy_bad, 0);
        check({tag, "_done_run"}, done_bad, 0);
        check({tag, "_hold_run"}, hold_bad, 0);
        @(posedge clk); #1;
        check({tag, "_done_e33"}, done, 1'b1);
        check({tag, "_busy_e33"}, busy, 1'b0);
        check({tag, "_hilo_e33"}, {HI, LO}, {ehi, elo});
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        int done_cnt;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6]  = '{3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[7]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{3'd2, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[10] = '{3'd1, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hilo", {HI, LO}, 64'd0);

        // Release reset with MTHI already presented: the first edge takes it.
        repeat (2) @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_lo", LO, 32'd0);
        check("mthi_busy", busy, 1'b0);
        check("mthi_done", done, 1'b0);
        m_hi = 32'h1234_5678;

        run_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        run_op("nop6", 3'd6, 32'h1111_1111, 32'h2222_2222, 0, 3'd0, 32'd0, 32'd0);
        run_op("nop7", 3'd7, 32'h3333_3333, 32'h4444_4444, 0, 3'd0, 32'd0, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, 3'd0, 32'd0, 32'd0);
            if (DIV_EN || vecs[i].op < 3'd2)
                check($sformatf("vec%0d_table", i), {HI, LO}, {vecs[i].hi, vecs[i].lo});
        end

        // DIVU presented mid-run is dropped; reissued in the done cycle.
        run_op("mulu3x5", 3'd1, 32'd3, 32'd5, 4, 3'd3, 32'd100, 32'd7);
        check("mulu3x5_hi", HI, 32'd0);
        check("mulu3x5_lo", LO, 32'd15);
        run_op("divu100_7", 3'd3, 32'd100, 32'd7, 0, 3'd0, 32'd0, 32'd0);
        if (DIV_EN)
            check("divu100_7_table", {HI, LO}, {32'd2, 32'd14});

        // MTLO and MTHI while busy are ignored.
        run_op("mt_busy_lo", 3'd0, 32'h0000_0011, 32'hFFFF_FFF0, 31, 3'd5, 32'hDEAD_BEEF, 32'd0);
        run_op("mt_busy_hi", 3'd1, 32'h0000_0101, 32'h0000_0202, 32, 3'd4, 32'hBEEF_DEAD, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 0, 3'd0, 32'd0, 32'd0);
        end

        // Reset ten iterations into a MULT.
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'hFFFF_FF00; B = 32'h0000_0777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hilo", {HI, LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_hilo_after", {HI, LO}, 64'd0);
        run_op("post_rst", 3'd0, 32'hFFFF_FFF6, 32'h0000_000A, 0, 3'd0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
